regwr_arb: RTL and testbench
============================

REGWR_ARB -- requirements
Module: regwr_arb

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the data width in bits.
REQ-002 Parameter NREQ SHALL default to 4 and set the requester count; the legal range SHALL be 2..8.
REQ-003 Parameter SW SHALL default to $clog2(NREQ) and set the width of the source-index field.
REQ-004 Port clk SHALL be an input, 1 bit wide, and be the sole clock; all state SHALL update on its rising edge.
REQ-005 Port reset SHALL be an input, 1 bit wide, with a synchronous, active-high reset.
REQ-006 Port ReqValid SHALL be an input, NREQ bits wide, with bit i meaning requester i has data.
REQ-007 Port ReqData SHALL be an input, NREQ*WIDTH bits wide, with slice [i*WIDTH +: WIDTH] carrying requester i's data.
REQ-008 Port ReqReady SHALL be an output, NREQ bits wide, with bit i meaning requester i's data is accepted this cycle.
REQ-009 Port OutValid SHALL be an output, 1 bit wide, meaning the holding register contains unconsumed data.
REQ-010 Port OutReady SHALL be an input, 1 bit wide, meaning the consumer accepts OutData this cycle.
REQ-011 Port OutData SHALL be an output, WIDTH bits wide, carrying the holding register contents.
REQ-012 Port OutSrc SHALL be an output, SW bits wide, carrying the requester index that wrote OutData.

Function
REQ-013 Storage SHALL be one enable-gated holding register (data plus source index) and one valid flag, FULL; no other data storage is permitted.
REQ-014 The state machine SHALL have two states: EMPTY (FULL=0) and LOADED (FULL=1); OutValid SHALL equal FULL.
REQ-015 Load permission SHALL be LoadOK = ~FULL | OutReady, which is combinational.
REQ-016 The grant SHALL be round-robin: among the asserted ReqValid bits, select the first index at or above pointer Ptr, wrapping modulo NREQ.
REQ-017 ReqReady SHALL be one-hot or zero: ReqReady[g]=1 only when LoadOK=1, ReqValid[g]=1, and g is the grant winner.
REQ-018 On a cycle with ReqReady[g]=1, the next edge SHALL load ReqData slice g into OutData and g into OutSrc, set FULL=1, and set Ptr=(g+1) mod NREQ.
REQ-019 On a cycle with FULL=1, OutReady=1 and no grant, the next edge SHALL clear FULL; OutData and OutSrc SHALL hold their values.
REQ-020 On a cycle with FULL=1, OutReady=1 and a grant, consume and reload SHALL occur on the same edge, giving a sustained throughput of one transfer per cycle.
REQ-021 Latency from request acceptance to OutValid SHALL be exactly 1 cycle; there SHALL be no combinational path from ReqData to OutData.
REQ-022 While OutValid=1 and OutReady=0, OutData, OutSrc and Ptr SHALL remain stable and all ReqReady bits SHALL be 0.
REQ-023 Ptr SHALL change only on a grant; idle cycles SHALL leave Ptr unchanged.
REQ-024 Fairness: a continuously asserted ReqValid[i] SHALL be granted within NREQ grants.
REQ-025 Wrap-around: with Ptr=NREQ-1 and only ReqValid[0] set, requester 0 SHALL win and Ptr SHALL become 1.
REQ-026 OutReady asserted while FULL=0 SHALL have no effect.
REQ-027 Requesters SHALL hold ReqValid and ReqData stable until ReqReady; the bench SHALL check this with an assertion, and the RTL SHALL NOT depend on it for correctness.

Reset
REQ-028 With reset=1 at a clock edge, that edge SHALL set FULL=0, Ptr=0, OutData=0 and OutSrc=0.
REQ-029 During the reset cycle, ReqReady SHALL be forced to 0, OutValid SHALL read 0 on the following cycle, and any in-flight or held data SHALL be discarded.
REQ-030 Reset SHALL take priority over simultaneous grant, consume and reload events.

Verification
REQ-031 Basic transfer (WIDTH=8, NREQ=4): after reset, set ReqValid=0100 and slice 2=0xA5 with OutReady=1 -> ReqReady=0100 that cycle; next cycle OutValid=1, OutData=0xA5, OutSrc=2.
REQ-032 Round-robin: hold ReqValid=1111 with OutReady=1 for 8 cycles -> the grant order SHALL be 0,1,2,3,0,1,2,3 and OutValid=1 on every cycle after the first.
REQ-033 Backpressure: load 0x3C from requester 1, then hold OutReady=0 for 5 cycles with ReqValid=1111 -> ReqReady=0000 throughout, and OutData=0x3C and OutSrc=1 stay stable.
REQ-034 Simultaneous consume and reload: with FULL=1 (0x11, src 0), OutReady=1 and ReqValid=1000 carrying 0x22 -> ReqReady=1000; next cycle OutValid=1, OutData=0x22, OutSrc=3, Ptr=0.
REQ-035 Wrap-around: with Ptr=3 and ReqValid=0001 -> requester 0 is granted and Ptr becomes 1.
REQ-036 Reset mid-operation: with FULL=1, OutReady=0 and Ptr=2, assert reset for 1 cycle with ReqValid=1111 -> ReqReady=0000 that cycle; next cycle OutValid=0, OutData=0, OutSrc=0, Ptr=0.

Source files
------------

// File: rtl/regwr_arb.sv
// Round-robin write arbiter: NREQ requesters share one registered output slot
// (data + source index + FULL) with valid/ready handshakes on both sides.

module regwr_arb_lane #(
  parameter int SW  = 2,
  parameter int IDX = 0
) (
  input  logic          req_valid,
  input  logic          gnt_en,
  input  logic [SW-1:0] gnt_idx,
  output logic          ready
);
  assign ready = gnt_en & req_valid & (gnt_idx == SW'(IDX));
endmodule

module regwr_arb #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int SW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       ReqValid,
  input  logic [NREQ*WIDTH-1:0] ReqData,
  output logic [NREQ-1:0]       ReqReady,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [WIDTH-1:0]      OutData,
  output logic [SW-1:0]         OutSrc
);
  typedef enum logic {EMPTY, LOADED} state_t;

  state_t           state, state_nxt;
  logic             full, load_ok, gnt_any, gnt_en;
  logic [SW-1:0]    gnt_idx, ptr, ptr_nxt;
  logic [WIDTH-1:0] data_q;
  logic [SW-1:0]    src_q;
  int               cand;

  assign full    = (state == LOADED);
  assign load_ok = ~full | OutReady;
  assign gnt_en  = gnt_any & load_ok & ~reset;

  // Scan from the farthest offset down so the nearest requester at/after ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = NREQ-1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (ReqValid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = SW'(cand);
      end
    end
  end

  assign ptr_nxt = (gnt_idx == SW'(NREQ-1)) ? '0 : gnt_idx + SW'(1);

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    regwr_arb_lane #(.SW(SW), .IDX(i)) u_lane (
      .req_valid (ReqValid[i]),
      .gnt_en    (gnt_en),
      .gnt_idx   (gnt_idx),
      .ready     (ReqReady[i])
    );
  end

  always_comb begin
    state_nxt = state;
    if (gnt_en)                state_nxt = LOADED;
    else if (full && OutReady) state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Holding register only moves on a grant, so a plain consume leaves data/src intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      src_q  <= '0;
      ptr    <= '0;
    end else if (gnt_en) begin
      data_q <= ReqData[int'(gnt_idx)*WIDTH +: WIDTH];
      src_q  <= gnt_idx;
      ptr    <= ptr_nxt;
    end
  end

  assign OutValid = full;
  assign OutData  = data_q;
  assign OutSrc   = src_q;
endmodule

// File: tb/tb_regwr_arb.sv
// Scoreboard bench for regwr_arb: directed scenarios followed by randomized
// traffic, checked against a queue-based reference model.

module tb_regwr_arb;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    rv;
  logic [N*W-1:0]  rd;
  logic [N-1:0]    rrdy;
  logic            ovld;
  logic            ordy;
  logic [W-1:0]    odata;
  logic [SW-1:0]   osrc;

  int checks = 0;
  int errors = 0;

  logic [W+SW-1:0] sb[$];
  int              mdl_ptr = 0;
  logic [W-1:0]    mdl_data = '0;
  logic [SW-1:0]   mdl_src = '0;
  int              wait_cnt[N];

  regwr_arb #(.WIDTH(W), .NREQ(N)) dut (
    .clk      (clk),
    .reset    (rst),
    .ReqValid (rv),
    .ReqData  (rd),
    .ReqReady (rrdy),
    .OutValid (ovld),
    .OutReady (ordy),
    .OutData  (odata),
    .OutSrc   (osrc)
  );

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_hold
    assert property (@(posedge clk) disable iff (rst)
      (rv[i] && !rrdy[i]) |=> (rv[i] && $stable(rd[i*W +: W])))
      else $error("requester %0d dropped or changed before ReqReady", i);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference arbitration: first valid index at or after ptr, modulo N.
  function automatic int mdl_grant();
    if (rst) return -1;
    if (!(sb.size() == 0 || ordy)) return -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (mdl_ptr + k) % N;
      if (rv[j]) return j;
    end
    return -1;
  endfunction

  // Advance one clock: update model with this cycle's inputs, then retire granted requests.
  task automatic step();
    int g;
    @(posedge clk);
    g = mdl_grant();
    if (rst) begin
      sb.delete();
      mdl_ptr  = 0;
      mdl_data = '0;
      mdl_src  = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else if (g >= 0) begin
      chk("fairness", wait_cnt[g] < N, 1'b1);
      for (int i = 0; i < N; i++) if (i != g && rv[i]) wait_cnt[i]++;
      wait_cnt[g] = 0;
      sb.push_back({rd[g*W +: W], SW'(g)});
      mdl_data = rd[g*W +: W];
      mdl_src  = SW'(g);
      mdl_ptr  = (g + 1) % N;
    end
    #1;
    if (g >= 0) rv[g] = 1'b0;
  endtask

  task automatic drain();
    ordy = 1'b1;
    for (int c = 0; c < 4*N && (rv != '0 || sb.size() != 0); c++) step();
    chk("drain_done", (rv == '0) && (sb.size() == 0), 1'b1);
  endtask

  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    g  = mdl_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", rrdy, er);
    chk("out_valid", ovld, sb.size() != 0);
    chk("out_data", odata, mdl_data);
    chk("out_src", osrc, mdl_src);
    chk("ptr", dut.ptr, mdl_ptr);
    if (ovld && sb.size() != 0) begin
      chk("sb_data", odata, sb[0][W+SW-1:SW]);
      chk("sb_src", osrc, sb[0][SW-1:0]);
      if (ordy) void'(sb.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    rst = 1'b1; rv = '0; rd = '0; ordy = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", ovld, 1'b0);
    chk("rst_data", odata, 8'h00);
    chk("rst_src", osrc, 2'd0);
    chk("rst_ptr", dut.ptr, 2'd0);

    // OutReady while empty is a no-op
    ordy = 1'b1; step();
    chk("idle_valid", ovld, 1'b0);
    chk("idle_ptr", dut.ptr, 2'd0);

    // Round-robin under full load
    rd = {$urandom};
    for (int c = 0; c < 8; c++) begin
      rv = 4'hF; #1;
      chk("rr_order", rrdy, 4'b0001 << (c % 4));
      step();
      chk("rr_valid", ovld, 1'b1);
    end
    drain();

    // Basic transfer
    rv = 4'b0100; rd[2*W +: W] = 8'hA5; ordy = 1'b1; #1;
    chk("basic_rr", rrdy, 4'b0100);
    step();
    chk("basic_valid", ovld, 1'b1);
    chk("basic_data", odata, 8'hA5);
    chk("basic_src", osrc, 2'd2);
    chk("basic_ptr", dut.ptr, 2'd3);
    step();
    chk("idle_keeps_ptr", dut.ptr, 2'd3);
    chk("consume_holds_data", odata, 8'hA5);

    // Wrap-around from ptr=3
    rv = 4'b0001; rd[0 +: W] = 8'h5A; #1;
    chk("wrap_rr", rrdy, 4'b0001);
    step();
    chk("wrap_ptr", dut.ptr, 2'd1);
    drain();

    // Backpressure
    rv = 4'b0010; rd[W +: W] = 8'h3C; ordy = 1'b1;
    step();
    ordy = 1'b0; rv = 4'hF;
    rd[0 +: W] = 8'h01; rd[2*W +: W] = 8'h02; rd[3*W +: W] = 8'h03;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_rr", rrdy, 4'b0000);
      step();
      chk("bp_data", odata, 8'h3C);
      chk("bp_src", osrc, 2'd1);
      chk("bp_ptr", dut.ptr, 2'd2);
    end
    drain();

    // Simultaneous consume and reload
    rv = 4'b0001; rd[0 +: W] = 8'h11; ordy = 1'b1;
    step();
    chk("sim_pre_data", odata, 8'h11);
    rv = 4'b1000; rd[3*W +: W] = 8'h22; #1;
    chk("sim_rr", rrdy, 4'b1000);
    step();
    chk("sim_valid", ovld, 1'b1);
    chk("sim_data", odata, 8'h22);
    chk("sim_src", osrc, 2'd3);
    chk("sim_ptr", dut.ptr, 2'd0);

    // Reset mid-operation
    rv = 4'b0010; rd[W +: W] = 8'h77;
    step();
    chk("pre_rst_ptr", dut.ptr, 2'd2);
    ordy = 1'b0; rv = 4'hF; rst = 1'b1; #1;
    chk("rst_rr", rrdy, 4'b0000);
    step();
    rst = 1'b0;
    chk("midrst_valid", ovld, 1'b0);
    chk("midrst_data", odata, 8'h00);
    chk("midrst_src", osrc, 2'd0);
    chk("midrst_ptr", dut.ptr, 2'd0);

    // Randomized traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!rv[i] && $urandom_range(1, 0) == 1) begin
          rv[i] = 1'b1;
          rd[i*W +: W] = W'($urandom);
        end
      ordy = ($urandom_range(9, 0) < 7);
      rst  = ($urandom_range(99, 0) == 0);
      step();
      rst = 1'b0;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
